// File: rtl/shift_word_pipe_if.sv
// Issue/writeback handshake bundle for shift_word_pipe: input op channel, result channel and flush.
interface shift_word_pipe_if #(
  parameter int TAG_W = 8
);
  logic             io_flush;
  logic             io_in_valid;
  logic             io_in_ready;
  logic [2:0]       io_in_op;
  logic [63:0]      io_in_src1;
  logic [63:0]      io_in_src2;
  logic [TAG_W-1:0] io_in_tag;
  logic             io_out_valid;
  logic             io_out_ready;
  logic [63:0]      io_out_data;
  logic [TAG_W-1:0] io_out_tag;

  modport master (
    output io_flush, io_in_valid, io_in_op, io_in_src1, io_in_src2, io_in_tag, io_out_ready,
    input  io_in_ready, io_out_valid, io_out_data, io_out_tag
  );

  modport slave (
    input  io_flush, io_in_valid, io_in_op, io_in_src1, io_in_src2, io_in_tag, io_out_ready,
    output io_in_ready, io_out_valid, io_out_data, io_out_tag
  );
endinterface

// File: rtl/shift_word_pipe.sv
// Two-stage 32-bit word shift/rotate unit (SLLW/SRLW/SRAW/ROLW/RORW) with sign-extended 64-bit result.
// Define SHIFT_WORD_ROT_EN to build ROLW/RORW; otherwise ops 3/4 return 0 like the reserved ops.
module shift_word_pipe #(
  parameter int TAG_W = 8
) (
  input  logic           clock,
  input  logic           reset,
  shift_word_pipe_if.slave bus
);

  localparam logic [2:0] OP_SLLW = 3'd0;
  localparam logic [2:0] OP_SRLW = 3'd1;
  localparam logic [2:0] OP_SRAW = 3'd2;
`ifdef SHIFT_WORD_ROT_EN
  localparam logic [2:0] OP_ROLW = 3'd3;
  localparam logic [2:0] OP_RORW = 3'd4;
`endif

  function automatic logic [31:0] shift_w(input logic [2:0] op, input logic [31:0] x,
                                          input logic [4:0] sh);
    logic signed [31:0] xs;
    xs = $signed(x);
    case (op)
      OP_SLLW: return x << sh;
      OP_SRLW: return x >> sh;
      OP_SRAW: return $unsigned(xs >>> sh);
      default: return 32'd0;
    endcase
  endfunction

`ifdef SHIFT_WORD_ROT_EN
  function automatic logic [31:0] rotate_w(input logic [2:0] op, input logic [31:0] x,
                                           input logic [4:0] sh, input logic [4:0] rev);
    case (op)
      OP_ROLW: return (x << sh) | (x >> rev);
      OP_RORW: return (x >> sh) | (x << rev);
      default: return 32'd0;
    endcase
  endfunction
`endif

  function automatic logic [63:0] sext_w(input logic [31:0] r);
    return {{32{r[31]}}, r};
  endfunction

  logic             vld_p1;
  logic             vld_p2;
  logic             adv_p1;
  logic             adv_p2;
  logic [31:0]      x_p1;
  logic [4:0]       shamt_p1;
  logic [2:0]       op_p1;
  logic [TAG_W-1:0] tag_p1;
`ifdef SHIFT_WORD_ROT_EN
  logic [4:0]       rev_shamt_p1;
`endif
  logic [31:0]      res_p1;
  logic [63:0]      data_p2;
  logic [TAG_W-1:0] tag_p2;
  logic             unused_hi;

  assign unused_hi = ^{bus.io_in_src1[63:32], bus.io_in_src2[63:5]};

  // No skid buffer: input readiness depends combinationally on the consumer.
  assign adv_p2 = !vld_p2 || bus.io_out_ready;
  assign adv_p1 = !vld_p1 || adv_p2;

  assign bus.io_in_ready  = adv_p1;
  assign bus.io_out_valid = vld_p2;
  assign bus.io_out_data  = data_p2;
  assign bus.io_out_tag   = tag_p2;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
    end else if (bus.io_flush) begin
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
    end else begin
      if (adv_p1) vld_p1 <= bus.io_in_valid;
      if (adv_p2) vld_p2 <= vld_p1;
    end
  end

  // Stage 1: operand capture
  always_ff @(posedge clock) begin
    if (adv_p1 && bus.io_in_valid) begin
      x_p1         <= bus.io_in_src1[31:0];
      shamt_p1     <= bus.io_in_src2[4:0];
      op_p1        <= bus.io_in_op;
      tag_p1       <= bus.io_in_tag;
`ifdef SHIFT_WORD_ROT_EN
      rev_shamt_p1 <= 5'd0 - bus.io_in_src2[4:0];
`endif
    end
  end

  always_comb begin
    res_p1 = shift_w(op_p1, x_p1, shamt_p1);
`ifdef SHIFT_WORD_ROT_EN
    if (op_p1 == OP_ROLW || op_p1 == OP_RORW)
      res_p1 = rotate_w(op_p1, x_p1, shamt_p1, rev_shamt_p1);
`endif
  end

  // Stage 2: result register; holds its value while empty or stalled
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      data_p2 <= 64'd0;
      tag_p2  <= '0;
    end else if (adv_p2 && vld_p1 && !bus.io_flush) begin
      data_p2 <= sext_w(res_p1);
      tag_p2  <= tag_p1;
    end
  end

endmodule

// File: tb/tb_shift_word_pipe.sv
// Scoreboard bench for shift_word_pipe: directed vectors, backpressure, flush and async reset.
module tb_shift_word_pipe;

  typedef struct {
    logic [7:0]  tag;
    logic [63:0] data;
    int          acc;
    int          lat;
  } exp_t;

  logic clock;
  logic reset;
  int   cyc;
  int   total;
  int   bad;
  exp_t sb[$];

  shift_word_pipe_if #(.TAG_W(8)) bus ();

  shift_word_pipe #(.TAG_W(8)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic send(input logic [2:0] op, input logic [63:0] s1, input logic [63:0] s2,
                      input logic [7:0] tag, input logic [63:0] exp, input int lat, input bit push);
    exp_t e;
    bit   ok;
    ok = 1'b0;
    bus.io_in_valid = 1'b1;
    bus.io_in_op    = op;
    bus.io_in_src1  = s1;
    bus.io_in_src2  = s2;
    bus.io_in_tag   = tag;
    for (int i = 0; i < 50; i++) begin
      @(negedge clock);
      if (bus.io_in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL send_timeout: tag %h never accepted", tag);
    end else if (push) begin
      e.tag  = tag;
      e.data = exp;
      e.acc  = cyc;
      e.lat  = lat;
      sb.push_back(e);
    end
    @(posedge clock);
    #1;
    bus.io_in_valid = 1'b0;
  endtask

  // Output monitor: pops the scoreboard on every result transfer, checks stall stability.
  initial begin : monitor
    exp_t        e;
    bit          pv, pr, pf;
    logic [63:0] pd;
    logic [7:0]  pt;
    pv = 0; pr = 0; pf = 0; pd = '0; pt = '0;
    forever begin
      @(negedge clock);
      if (reset) begin
        if (pv && !pr && !pf) begin
          chk("hold_valid", 64'(bus.io_out_valid), 64'd1);
          chk("hold_data", bus.io_out_data, pd);
          chk("hold_tag", 64'(bus.io_out_tag), 64'(pt));
        end
        if (bus.io_out_valid && bus.io_out_ready) begin
          if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_out: tag %h data %h with nothing expected",
                     bus.io_out_tag, bus.io_out_data);
          end else begin
            e = sb.pop_front();
            chk("out_tag", 64'(bus.io_out_tag), 64'(e.tag));
            chk("out_data", bus.io_out_data, e.data);
            if (e.lat >= 0) chk("latency", 64'(cyc - e.acc), 64'(e.lat));
          end
        end
        pv = bus.io_out_valid;
        pr = bus.io_out_ready;
        pf = bus.io_flush;
        pd = bus.io_out_data;
        pt = bus.io_out_tag;
      end else begin
        pv = 0;
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    total = 0;
    bad   = 0;
    cyc   = 0;
    reset = 1'b0;
    bus.io_flush     = 1'b0;
    bus.io_in_valid  = 1'b0;
    bus.io_in_op     = 3'd0;
    bus.io_in_src1   = '0;
    bus.io_in_src2   = '0;
    bus.io_in_tag    = '0;
    bus.io_out_ready = 1'b1;
    #1;
    chk("rst_out_valid", 64'(bus.io_out_valid), 64'd0);
    chk("rst_out_data", bus.io_out_data, 64'd0);
    chk("rst_out_tag", 64'(bus.io_out_tag), 64'd0);
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;
    chk("rst_in_ready", 64'(bus.io_in_ready), 64'd1);

    // Directed vectors, back to back at full throughput.
    send(3'd2, 64'h0000_0000_8000_0000, 64'd4,  8'h10, 64'hFFFF_FFFF_F800_0000, 2, 1);
    send(3'd0, 64'h1234_5678_0000_0001, 64'h3F, 8'h11, 64'hFFFF_FFFF_8000_0000, 2, 1);
    send(3'd1, 64'h1234_5678_0000_0001, 64'h3F, 8'h12, 64'h0000_0000_0000_0000, 2, 1);
    send(3'd1, 64'h0000_0000_F000_0000, 64'd4,  8'h13, 64'h0000_0000_0F00_0000, 2, 1);
    send(3'd0, 64'h0000_0000_0000_0001, 64'h20, 8'h14, 64'h0000_0000_0000_0001, 2, 1);
    send(3'd5, 64'h0000_0000_FFFF_FFFF, 64'd3,  8'h15, 64'h0000_0000_0000_0000, 2, 1);
`ifdef SHIFT_WORD_ROT_EN
    send(3'd3, 64'h0000_0000_8000_0001, 64'd1,  8'h16, 64'h0000_0000_0000_0003, 2, 1);
    send(3'd4, 64'h0000_0000_8000_0001, 64'd1,  8'h17, 64'hFFFF_FFFF_C000_0000, 2, 1);
    send(3'd3, 64'h0000_0000_8765_4321, 64'd0,  8'h18, 64'hFFFF_FFFF_8765_4321, 2, 1);
    send(3'd4, 64'h0000_0000_8765_4321, 64'd0,  8'h19, 64'hFFFF_FFFF_8765_4321, 2, 1);
`else
    send(3'd3, 64'h0000_0000_8000_0001, 64'd1,  8'h16, 64'h0000_0000_0000_0000, 2, 1);
    send(3'd4, 64'h0000_0000_8000_0001, 64'd1,  8'h17, 64'h0000_0000_0000_0000, 2, 1);
    send(3'd3, 64'h0000_0000_8765_4321, 64'd0,  8'h18, 64'h0000_0000_0000_0000, 2, 1);
    send(3'd4, 64'h0000_0000_8765_4321, 64'd0,  8'h19, 64'h0000_0000_0000_0000, 2, 1);
`endif
    repeat (4) @(posedge clock);
    #1;

    // Backpressure: tags 1..5 streamed while the consumer stalls for four cycles.
    fork
      begin
        send(3'd0, 64'd1, 64'd1, 8'd1, 64'd2,  -1, 1);
        send(3'd0, 64'd1, 64'd2, 8'd2, 64'd4,  -1, 1);
        send(3'd0, 64'd1, 64'd3, 8'd3, 64'd8,  -1, 1);
        send(3'd0, 64'd1, 64'd4, 8'd4, 64'd16, -1, 1);
        send(3'd0, 64'd1, 64'd5, 8'd5, 64'd32, -1, 1);
      end
      begin
        repeat (2) @(posedge clock);
        #1;
        bus.io_out_ready = 1'b0;
        @(negedge clock);
        chk("full_in_ready", 64'(bus.io_in_ready), 64'd0);
        repeat (4) @(posedge clock);
        #1;
        bus.io_out_ready = 1'b1;
      end
    join
    repeat (4) @(posedge clock);
    #1;

    // Flush with both stages occupied and an input presented the same cycle.
    bus.io_out_ready = 1'b0;
    send(3'd0, 64'd1, 64'd1, 8'hA1, 64'd0, -1, 0);
    send(3'd0, 64'd1, 64'd2, 8'hA2, 64'd0, -1, 0);
    chk("pre_flush_valid", 64'(bus.io_out_valid), 64'd1);
    bus.io_flush    = 1'b1;
    bus.io_in_valid = 1'b1;
    bus.io_in_tag   = 8'hA3;
    @(posedge clock);
    #1;
    bus.io_flush    = 1'b0;
    bus.io_in_valid = 1'b0;
    chk("flush_out_valid", 64'(bus.io_out_valid), 64'd0);
    bus.io_out_ready = 1'b1;
    repeat (4) @(posedge clock);
    #1;
    send(3'd2, 64'h0000_0000_8000_0000, 64'd4, 8'hB0, 64'hFFFF_FFFF_F800_0000, 2, 1);
    repeat (4) @(posedge clock);
    #1;

    // Asynchronous reset between edges with ops in flight.
    bus.io_out_ready = 1'b0;
    send(3'd0, 64'd3, 64'd1, 8'hC1, 64'd0, -1, 0);
    send(3'd0, 64'd3, 64'd2, 8'hC2, 64'd0, -1, 0);
    chk("pre_rst_valid", 64'(bus.io_out_valid), 64'd1);
    #2;
    reset = 1'b0;
    #1;
    chk("async_rst_valid", 64'(bus.io_out_valid), 64'd0);
    chk("async_rst_data", bus.io_out_data, 64'd0);
    chk("async_rst_tag", 64'(bus.io_out_tag), 64'd0);
    repeat (2) @(posedge clock);
    #3;
    reset = 1'b1;
    bus.io_out_ready = 1'b1;
    repeat (4) @(posedge clock);
    #1;
    chk("post_rst_idle", 64'(bus.io_out_valid), 64'd0);
    send(3'd1, 64'h0000_0000_8000_0000, 64'd31, 8'hD0, 64'h0000_0000_0000_0001, 2, 1);

    for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge clock);
    @(negedge clock);
    chk("sb_drained", 64'(sb.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
